// File: rtl/spi_engine.sv
// SPI mode-0 master that streams words between a TX FIFO and an RX FIFO.
// One transaction moves len words; op selects full-duplex read or write-only.
module spi_engine #(
    parameter int unsigned DATA    = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     len,
    input  logic            op,
    input  logic            work,
    output logic            busy,
    input  logic [DATA-1:0] tx_data,
    output logic            tx_rd,
    input  logic            tx_empty,
    output logic [DATA-1:0] rx_data,
    output logic            rx_wr,
    input  logic            rx_full,
    output logic            sclk,
    output logic            cs_n,
    output logic            mosi,
    input  logic            miso
);

    localparam int unsigned     BitW    = (DATA > 1) ? $clog2(DATA) : 1;
    localparam logic [7:0]      DivLast = 8'(CLK_DIV - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StSetup,
        StShift,
        StStore,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [7:0]        div_q, div_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DATA-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA-1:0]   rx_sr_q, rx_sr_d;
    logic [DATA-1:0]   rx_data_q, rx_data_d;
    logic              busy_q, busy_d;
    logic              tx_rd_q, tx_rd_d;
    logic              rx_wr_q, rx_wr_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              mosi_q, mosi_d;
    logic              div_last;

    assign div_last = (div_q == DivLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        busy_d    = busy_q;
        tx_rd_d   = 1'b0;
        rx_wr_d   = 1'b0;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;

        unique case (state_q)
            StIdle: begin
                if (work && (len != 16'd0)) begin
                    cnt_d   = len;
                    op_d    = op;
                    busy_d  = 1'b1;
                    state_d = StFetch;
                end
            end

            StFetch: begin
                sclk_d = 1'b0;
                if (op_q) begin
                    if (!tx_empty) begin
                        tx_rd_d = 1'b1;
                        state_d = StLatch;
                    end
                end else if (!rx_full) begin
                    if (!tx_empty) begin
                        tx_rd_d = 1'b1;
                        state_d = StLatch;
                    end else begin
                        // TX underrun in duplex mode: clock out zeros so the read still happens
                        tx_sr_d = '0;
                        mosi_d  = 1'b0;
                        cs_n_d  = 1'b0;
                        div_d   = 8'd0;
                        state_d = StSetup;
                    end
                end
            end

            StLatch: begin
                // tx_data is only valid the cycle after the pop strobe
                if (!tx_rd_q) begin
                    tx_sr_d = tx_data;
                    mosi_d  = tx_data[DATA-1];
                    cs_n_d  = 1'b0;
                    div_d   = 8'd0;
                    state_d = StSetup;
                end
            end

            StSetup: begin
                if (div_last) begin
                    div_d   = 8'd0;
                    sclk_d  = 1'b1;
                    rx_sr_d = {rx_sr_q[DATA-2:0], miso};
                    bit_d   = '0;
                    state_d = StShift;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            StShift: begin
                if (!div_last) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = 8'd0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_q == BitLast) begin
                            state_d = StStore;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            tx_sr_d = {tx_sr_q[DATA-2:0], 1'b0};
                            mosi_d  = tx_sr_q[DATA-2];
                        end
                    end else begin
                        sclk_d  = 1'b1;
                        rx_sr_d = {rx_sr_q[DATA-2:0], miso};
                    end
                end
            end

            StStore: begin
                if (!op_q) begin
                    rx_data_d = rx_sr_q;
                    rx_wr_d   = 1'b1;
                end
                cnt_d   = cnt_q - 16'd1;
                div_d   = 8'd0;
                state_d = (cnt_q == 16'd1) ? StHold : StFetch;
            end

            StHold: begin
                if (div_last) begin
                    div_d   = 8'd0;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 16'd0;
            op_q      <= 1'b0;
            div_q     <= 8'd0;
            bit_q     <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            tx_rd_q   <= 1'b0;
            rx_wr_q   <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
        end
    end

    assign busy    = busy_q;
    assign tx_rd   = tx_rd_q;
    assign rx_wr   = rx_wr_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_engine.sv
// Directed bench for spi_engine: FIFO models, a mode-0 slave and per-scenario tasks.
module tb_spi_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] len;
    logic        op, work, busy;
    logic [7:0]  tx_data;
    logic        tx_rd, tx_empty;
    logic [7:0]  rx_data;
    logic        rx_wr, rx_full;
    logic        sclk, cs_n, mosi, miso;

    logic        work2, busy2, tx_rd2, rx_wr2, sclk2, cs_n2, mosi2;
    logic [7:0]  rx_data2;
    logic [15:0] len2      = 16'd1;
    logic        op2       = 1'b1;
    logic [7:0]  tx_data2  = 8'hA5;
    logic        tx_empty2 = 1'b0;
    logic        rx_full2  = 1'b0;
    logic        miso2     = 1'b0;

    int total = 0;
    int bad   = 0;

    spi_engine #(.DATA(8), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .len(len), .op(op), .work(work), .busy(busy),
        .tx_data(tx_data), .tx_rd(tx_rd), .tx_empty(tx_empty),
        .rx_data(rx_data), .rx_wr(rx_wr), .rx_full(rx_full),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    spi_engine #(.DATA(8), .CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .len(len2), .op(op2), .work(work2), .busy(busy2),
        .tx_data(tx_data2), .tx_rd(tx_rd2), .tx_empty(tx_empty2),
        .rx_data(rx_data2), .rx_wr(rx_wr2), .rx_full(rx_full2),
        .sclk(sclk2), .cs_n(cs_n2), .mosi(mosi2), .miso(miso2)
    );

    // TX FIFO model: data appears the cycle after the pop
    logic [7:0] tx_mem [0:63];
    int tx_wp = 0, tx_rp = 0, tx_rd_n = 0;
    assign tx_empty = (tx_wp == tx_rp);
    always @(posedge clk) begin
        if (tx_rd === 1'b1) begin
            tx_data <= tx_mem[tx_rp % 64];
            tx_rp   <= tx_rp + 1;
            tx_rd_n <= tx_rd_n + 1;
        end
    end

    logic [7:0] rx_log [0:63];
    int rx_n = 0;
    always @(posedge clk) begin
        if (rx_wr === 1'b1) begin
            rx_log[rx_n % 64] <= rx_data;
            rx_n <= rx_n + 1;
        end
    end

    // Slave: shifts the next bit out on every falling sclk while selected
    logic [7:0] sl_words [0:7];
    int fall_n = 0, sl_base = 0, sk;
    always @(negedge sclk) if (cs_n === 1'b0) fall_n <= fall_n + 1;
    assign sk   = fall_n - sl_base;
    assign miso = sl_words[(sk / 8) % 8][7 - (sk % 8)];

    logic mo_bits [0:1023];
    int rise_n = 0;
    always @(posedge sclk) begin
        mo_bits[rise_n % 1024] <= mosi;
        rise_n <= rise_n + 1;
    end

    int cs_fall_n = 0, busy_rise_n = 0, viol = 0;
    always @(negedge cs_n) cs_fall_n <= cs_fall_n + 1;
    always @(posedge busy) busy_rise_n <= busy_rise_n + 1;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (tx_rd === 1'b1 && rx_wr === 1'b1) viol <= viol + 1;
            if ((tx_rd === 1'b1 || rx_wr === 1'b1) && busy !== 1'b1) viol <= viol + 1;
            if (sclk === 1'b1 && cs_n === 1'b1) viol <= viol + 1;
        end
    end

    function automatic logic [7:0] mo_word(input int base, input int w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = mo_bits[(base + 8*w + i) % 1024];
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        tx_mem[tx_wp % 64] = d;
        tx_wp = tx_wp + 1;
    endtask

    task automatic start(input logic o, input logic [15:0] l);
        op = o; len = l; work = 1'b1;
        tick(1);
        work = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; work = 1'b0; work2 = 1'b0; len = 16'd0; op = 1'b0; rx_full = 1'b0;
        tick(2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b want=1", cs_n); end
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk); end
        total++; if (mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b want=0", mosi); end
        total++; if (tx_rd !== 1'b0 || rx_wr !== 1'b0) begin
            bad++; $display("FAIL reset_strobes got=%b%b want=00", tx_rd, rx_wr);
        end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
        rst = 1'b0;
        tick(3);
        total++; if (busy !== 1'b0 || cs_n !== 1'b1) begin
            bad++; $display("FAIL reset_idle got busy=%b cs_n=%b want 0/1", busy, cs_n);
        end
    endtask

    task automatic test_duplex;
        logic [7:0] ex_tx [3];
        logic [7:0] ex_rx [3];
        int rb, tb0, rxb;
        bit ok;
        ex_tx[0] = 8'h00; ex_tx[1] = 8'h19; ex_tx[2] = 8'h00;
        ex_rx[0] = 8'hA5; ex_rx[1] = 8'h3C; ex_rx[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin push(ex_tx[i]); sl_words[i] = ex_rx[i]; end
        sl_base = fall_n; rb = rise_n; tb0 = tx_rd_n; rxb = rx_n;
        start(1'b0, 16'd3);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL duplex_busy got=%b want=1", busy); end
        wait_idle(2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL duplex_done got=busy want=idle"); end
        total++; if (tx_rd_n - tb0 != 3) begin bad++; $display("FAIL duplex_tx_rd got=%0d want=3", tx_rd_n - tb0); end
        total++; if (rx_n - rxb != 3) begin bad++; $display("FAIL duplex_rx_wr got=%0d want=3", rx_n - rxb); end
        total++; if (rise_n - rb != 24) begin bad++; $display("FAIL duplex_sclk got=%0d want=24", rise_n - rb); end
        for (int w = 0; w < 3; w++) begin
            total++; if (rx_log[(rxb + w) % 64] !== ex_rx[w]) begin
                bad++; $display("FAIL duplex_rx%0d got=%h want=%h", w, rx_log[(rxb + w) % 64], ex_rx[w]);
            end
            total++; if (mo_word(rb, w) !== ex_tx[w]) begin
                bad++; $display("FAIL duplex_mosi%0d got=%h want=%h", w, mo_word(rb, w), ex_tx[w]);
            end
        end
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL duplex_cs_n got=%b want=1", cs_n); end
    endtask

    task automatic test_filler;
        logic [7:0] ex_tx [5];
        logic [7:0] ex_rx [5];
        int rb, tb0, rxb;
        bit ok;
        ex_tx[0] = 8'h9F; ex_tx[1] = 8'h01; ex_tx[2] = 8'h00; ex_tx[3] = 8'h00; ex_tx[4] = 8'h00;
        ex_rx[0] = 8'h11; ex_rx[1] = 8'h22; ex_rx[2] = 8'h33; ex_rx[3] = 8'h44; ex_rx[4] = 8'h55;
        push(8'h9F); push(8'h01);
        for (int i = 0; i < 5; i++) sl_words[i] = ex_rx[i];
        sl_base = fall_n; rb = rise_n; tb0 = tx_rd_n; rxb = rx_n;
        start(1'b0, 16'd5);
        wait_idle(3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL filler_done got=busy want=idle"); end
        total++; if (tx_rd_n - tb0 != 2) begin bad++; $display("FAIL filler_tx_rd got=%0d want=2", tx_rd_n - tb0); end
        total++; if (rx_n - rxb != 5) begin bad++; $display("FAIL filler_rx_wr got=%0d want=5", rx_n - rxb); end
        for (int w = 0; w < 5; w++) begin
            total++; if (mo_word(rb, w) !== ex_tx[w]) begin
                bad++; $display("FAIL filler_mosi%0d got=%h want=%h", w, mo_word(rb, w), ex_tx[w]);
            end
            total++; if (rx_log[(rxb + w) % 64] !== ex_rx[w]) begin
                bad++; $display("FAIL filler_rx%0d got=%h want=%h", w, rx_log[(rxb + w) % 64], ex_rx[w]);
            end
        end
    endtask

    task automatic test_write_stall;
        int rb, tb0, rxb, cb, err;
        bit ok;
        sl_base = fall_n; rb = rise_n; tb0 = tx_rd_n; rxb = rx_n; cb = cs_fall_n;
        start(1'b1, 16'd2);
        err = 0;
        repeat (20) begin
            if (sclk !== 1'b0 || cs_n !== 1'b1) err++;
            tick(1);
        end
        total++; if (err != 0) begin bad++; $display("FAIL wstall_first got=%0d bad cycles want=0", err); end
        total++; if (tx_rd_n != tb0) begin bad++; $display("FAIL wstall_no_pop got=%0d want=0", tx_rd_n - tb0); end
        push(8'h55);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rise_n - rb == 8 && sclk === 1'b0) begin ok = 1'b1; break; end
            tick(1);
        end
        total++; if (!ok) begin bad++; $display("FAIL wstall_word1 got=%0d rises want=8", rise_n - rb); end
        err = 0;
        repeat (20) begin
            if (sclk !== 1'b0 || cs_n !== 1'b0 || rise_n - rb != 8) err++;
            tick(1);
        end
        total++; if (err != 0) begin bad++; $display("FAIL wstall_second got=%0d bad cycles want=0", err); end
        push(8'hAA);
        wait_idle(1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL wstall_done got=busy want=idle"); end
        total++; if (mo_word(rb, 0) !== 8'h55 || mo_word(rb, 1) !== 8'hAA) begin
            bad++; $display("FAIL wstall_mosi got=%h%h want=55AA", mo_word(rb, 0), mo_word(rb, 1));
        end
        total++; if (rx_n != rxb) begin bad++; $display("FAIL wstall_rx_wr got=%0d want=0", rx_n - rxb); end
        total++; if (tx_rd_n - tb0 != 2) begin bad++; $display("FAIL wstall_tx_rd got=%0d want=2", tx_rd_n - tb0); end
        total++; if (cs_fall_n - cb != 1) begin bad++; $display("FAIL wstall_cs_fall got=%0d want=1", cs_fall_n - cb); end
    endtask

    task automatic test_rx_stall;
        int rb, tb0, rxb, err;
        bit ok;
        push(8'hC3); push(8'h5A);
        sl_words[0] = 8'h96; sl_words[1] = 8'h0F;
        sl_base = fall_n; rb = rise_n; tb0 = tx_rd_n; rxb = rx_n;
        start(1'b0, 16'd2);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rx_wr === 1'b1) begin ok = 1'b1; break; end
            tick(1);
        end
        total++; if (!ok) begin bad++; $display("FAIL rstall_first_wr got=none want=rx_wr"); end
        rx_full = 1'b1;
        err = 0;
        repeat (30) begin
            tick(1);
            if (sclk !== 1'b0 || cs_n !== 1'b0 || rise_n - rb != 8) err++;
        end
        total++; if (err != 0) begin bad++; $display("FAIL rstall_hold got=%0d bad cycles want=0", err); end
        rx_full = 1'b0;
        wait_idle(1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstall_done got=busy want=idle"); end
        total++; if (rx_n - rxb != 2) begin bad++; $display("FAIL rstall_rx_wr got=%0d want=2", rx_n - rxb); end
        total++; if (rx_log[(rxb + 1) % 64] !== 8'h0F) begin
            bad++; $display("FAIL rstall_rx1 got=%h want=0f", rx_log[(rxb + 1) % 64]);
        end
        total++; if (mo_word(rb, 1) !== 8'h5A) begin bad++; $display("FAIL rstall_mosi1 got=%h want=5a", mo_word(rb, 1)); end
    endtask

    task automatic test_abort;
        int rb, tb0, rxb;
        bit ok;
        push(8'h3C);
        sl_words[0] = 8'hE7;
        sl_base = fall_n; rb = rise_n;
        start(1'b0, 16'd2);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rise_n - rb == 5) begin ok = 1'b1; break; end
            tick(1);
        end
        total++; if (!ok) begin bad++; $display("FAIL abort_bit4 got=%0d rises want=5", rise_n - rb); end
        rst = 1'b1;
        #1;
        total++; if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_now got cs_n=%b sclk=%b busy=%b want 1/0/0", cs_n, sclk, busy);
        end
        tick(2);
        rst = 1'b0;
        tb0 = tx_rd_n; rxb = rx_n;
        tick(40);
        total++; if (tx_rd_n != tb0 || rx_n != rxb) begin
            bad++; $display("FAIL abort_strobes got=%0d/%0d want=0/0", tx_rd_n - tb0, rx_n - rxb);
        end
        total++; if (busy !== 1'b0 || cs_n !== 1'b1) begin
            bad++; $display("FAIL abort_idle got busy=%b cs_n=%b want 0/1", busy, cs_n);
        end
        push(8'h81);
        sl_words[0] = 8'h7E;
        sl_base = fall_n; rb = rise_n; tb0 = tx_rd_n; rxb = rx_n;
        start(1'b0, 16'd1);
        wait_idle(1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL abort_redo got=busy want=idle"); end
        total++; if (rx_n - rxb != 1 || rx_log[rxb % 64] !== 8'h7E) begin
            bad++; $display("FAIL abort_redo_rx got=%0d/%h want=1/7e", rx_n - rxb, rx_log[rxb % 64]);
        end
        total++; if (mo_word(rb, 0) !== 8'h81 || tx_rd_n - tb0 != 1) begin
            bad++; $display("FAIL abort_redo_tx got=%h/%0d want=81/1", mo_word(rb, 0), tx_rd_n - tb0);
        end
    endtask

    task automatic test_ignored;
        int cb, br, rb, tb0, rxb;
        bit ok;
        cb = cs_fall_n; br = busy_rise_n;
        len = 16'd0; op = 1'b0; work = 1'b1;
        tick(3);
        work = 1'b0;
        tick(2);
        total++; if (busy !== 1'b0 || cs_fall_n != cb || busy_rise_n != br) begin
            bad++; $display("FAIL len0 got busy=%b cs=%0d tr=%0d want 0/0/0", busy, cs_fall_n - cb, busy_rise_n - br);
        end
        push(8'h42);
        rb = rise_n; tb0 = tx_rd_n; rxb = rx_n;
        start(1'b1, 16'd1);
        len = 16'd3; op = 1'b0; work = 1'b1;
        tick(10);
        work = 1'b0;
        wait_idle(1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL busy_work_done got=busy want=idle"); end
        total++; if (busy_rise_n - br != 1 || cs_fall_n - cb != 1) begin
            bad++; $display("FAIL busy_work_count got=%0d/%0d want=1/1", busy_rise_n - br, cs_fall_n - cb);
        end
        total++; if (tx_rd_n - tb0 != 1 || rx_n != rxb || mo_word(rb, 0) !== 8'h42) begin
            bad++; $display("FAIL busy_work_data got=%0d/%0d/%h want=1/0/42", tx_rd_n - tb0, rx_n - rxb, mo_word(rb, 0));
        end
    endtask

    task automatic test_clkdiv2;
        int cyc_cs, nr, hi;
        int r [3];
        logic ps;
        bit ok;
        cyc_cs = -1; nr = 0; hi = 0;
        r[0] = 0; r[1] = 0; r[2] = 0;
        work2 = 1'b1;
        tick(1);
        work2 = 1'b0;
        ps = sclk2;
        for (int i = 0; i < 200 && nr < 3; i++) begin
            tick(1);
            if (cs_n2 === 1'b0 && cyc_cs < 0) cyc_cs = i;
            if (sclk2 === 1'b1 && ps === 1'b0) begin r[nr] = i; nr++; end
            if (sclk2 === 1'b1 && nr == 1) hi++;
            ps = sclk2;
        end
        total++; if (nr != 3) begin bad++; $display("FAIL div2_rises got=%0d want=3", nr); end
        total++; if (r[1] - r[0] != 4 || r[2] - r[1] != 4) begin
            bad++; $display("FAIL div2_period got=%0d/%0d want=4/4", r[1] - r[0], r[2] - r[1]);
        end
        total++; if (hi != 2) begin bad++; $display("FAIL div2_high got=%0d want=2", hi); end
        total++; if (r[0] - cyc_cs != 2) begin bad++; $display("FAIL div2_lead got=%0d want=2", r[0] - cyc_cs); end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy2 === 1'b0) begin ok = 1'b1; break; end
            tick(1);
        end
        total++; if (!ok || cs_n2 !== 1'b1) begin bad++; $display("FAIL div2_done got cs_n=%b want=1", cs_n2); end
    endtask

    initial begin
        test_reset;
        test_duplex;
        test_filler;
        test_write_stall;
        test_rx_stall;
        test_abort;
        test_ignored;
        test_clkdiv2;
        total++; if (viol != 0) begin bad++; $display("FAIL protocol got=%0d violations want=0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_engine.md
SPI_ENGINE -- requirements
Module: spi_engine

Interface
REQ-001 SHALL have parameter DATA, default 8, bits per SPI word and per FIFO entry.
REQ-002 SHALL have parameter CLK_DIV, default 4, clk cycles per SCLK half-period (legal range 2..255).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port len  input  16  number of words in the transaction; sampled with work.
REQ-006 SHALL have port op  input  1  transaction mode (0 = full-duplex read, 1 = write-only); sampled with work.
REQ-007 SHALL have port work  input  1  start request; sampled only while busy=0.
REQ-008 SHALL have port busy  output  1  high while a transaction is in progress.
REQ-009 SHALL have port tx_data  input  DATA  TX FIFO read data, valid one clk after tx_rd.
REQ-010 SHALL have port tx_rd  output  1  TX FIFO pop strobe, one clk wide.
REQ-011 SHALL have port tx_empty  input  1  TX FIFO empty flag.
REQ-012 SHALL have port rx_data  output  DATA  RX FIFO write data.
REQ-013 SHALL have port rx_wr  output  1  RX FIFO push strobe, one clk wide.
REQ-014 SHALL have port rx_full  input  1  RX FIFO full flag.
REQ-015 SHALL have ports sclk (output, 1), cs_n (output, 1), mosi (output, 1), miso (input, 1): SPI mode 0 pins.

Function
REQ-016 SHALL implement states IDLE, FETCH, LATCH, SETUP, SHIFT, STORE, HOLD.
REQ-017 IDLE: work=1 with len!=0 -> latch len/op into internal registers, busy=1 next cycle, go FETCH; work=1 with len=0 -> ignored, busy stays 0.
REQ-018 work while busy=1 SHALL be ignored; len/op changes during a transaction SHALL have no effect.
REQ-019 FETCH, op=1: wait (sclk low, cs_n unchanged) while tx_empty=1; when tx_empty=0, pulse tx_rd one cycle, go LATCH.
REQ-020 FETCH, op=0: wait while rx_full=1; then if tx_empty=0 pulse tx_rd and go LATCH, else load shift register with all-zero filler and go SETUP.
REQ-021 LATCH: capture tx_data into shift register, go SETUP.
REQ-022 SETUP: cs_n=0 (first word: held low CLK_DIV cycles before first SCLK rise); mosi = shift-register MSB.
REQ-023 SHIFT: DATA SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high; miso sampled into receive register on the clk that raises sclk; mosi advances to next bit on the clk that drops sclk; MSB first.
REQ-024 STORE: op=0 -> rx_data = received word, rx_wr pulse one cycle; op=1 -> received word discarded, no rx_wr; decrement word counter.
REQ-025 After STORE: counter!=0 -> FETCH with cs_n held low, sclk low; counter=0 -> HOLD.
REQ-026 HOLD: keep cs_n=0 and sclk=0 for CLK_DIV cycles, then cs_n=1, busy=0, return IDLE; next work accepted the cycle after busy falls.
REQ-027 tx_rd and rx_wr SHALL never be asserted in the same cycle and never outside busy=1.
REQ-028 sclk SHALL be low whenever cs_n=1 and during all FETCH/LATCH waits (stall never truncates a bit).
REQ-029 Word counter SHALL be 16 bits; len=16'hFFFF completes 65535 words without wrap.

Reset
REQ-030 rst=1 SHALL immediately force: state IDLE, busy=0, cs_n=1, sclk=0, mosi=0, tx_rd=0, rx_wr=0, rx_data=0, counters 0.
REQ-031 rst asserted mid-transaction SHALL abort with no further FIFO strobes; after release, block waits in IDLE for a new work.

Verification
REQ-032 op=0, len=3, TX FIFO holds 0x00,0x19,0x00, miso slave returns 0xA5,0x3C,0xFF -> mosi carries 00,19,00; three tx_rd; RX FIFO receives A5,3C,FF; busy low after HOLD.
REQ-033 op=0, len=5, TX holds 2 words (0x9F,0x01) -> words 3..5 send 0x00; 2 tx_rd; 5 rx_wr.
REQ-034 op=1, len=2, TX initially empty, 0x55 pushed after 20 clk, 0xAA after 60 -> sclk idle low until each word present; mosi 55 then AA; zero rx_wr.
REQ-035 op=0, len=2, rx_full=1 held 30 clk before second word -> no sclk activity and cs_n stays low during stall; second word shifted after release; exactly 2 rx_wr.
REQ-036 rst pulsed during bit 4 of word 1 -> cs_n=1, sclk=0, busy=0 same cycle; no tx_rd/rx_wr after; new work op=0 len=1 completes normally.
REQ-037 len=0 with work=1, and work=1 while busy -> no cs_n activity, transaction count unchanged; CLK_DIV=2 variant checks SCLK period = 4 clk.
